// File: rtl/cpu_sequencer.sv
// cpu_sequencer: fetch/decode/execute control FSM for the 8-bit accumulator CPU with a memory wait-state timeout.
// Optional SEQ_SINGLE_STEP_EN adds a step input and a STEP state that gates each instruction.
module cpu_sequencer #(
    parameter int OP_W     = 3,
    parameter int WAIT_MAX = 15
) (
    input  logic            clock,
    input  logic            reset,
    input  logic [OP_W-1:0] op,
    input  logic            z_flag,
    input  logic            mem_ready,
`ifdef SEQ_SINGLE_STEP_EN
    input  logic            step,
`endif
    output logic            PC_bus,
    output logic            INC_PC,
    output logic            load_PC,
    output logic            load_MAR,
    output logic            load_IR,
    output logic            MDR_bus,
    output logic            load_MDR,
    output logic            ACC_bus,
    output logic            load_ACC,
    output logic            sw_bus,
    output logic            Addr_bus,
    output logic [1:0]      ALU_sel,
    output logic            mem_req,
    output logic            CS,
    output logic            R_NW,
    output logic            halted,
    output logic            bus_error
);
    typedef enum logic [3:0] {
        F0, F1, F2, DEC, E_RD, E_EX, E_WR, HALT, ERR
`ifdef SEQ_SINGLE_STEP_EN
        , STEP
`endif
    } state_t;

`ifdef SEQ_SINGLE_STEP_EN
    localparam state_t HOME = STEP;
`else
    localparam state_t HOME = F0;
`endif

    localparam logic [OP_W-1:0] OP_LOAD  = OP_W'(0);
    localparam logic [OP_W-1:0] OP_STORE = OP_W'(1);
    localparam logic [OP_W-1:0] OP_ADD   = OP_W'(2);
    localparam logic [OP_W-1:0] OP_SUB   = OP_W'(3);
    localparam logic [OP_W-1:0] OP_BNE   = OP_W'(4);
    localparam logic [OP_W-1:0] OP_BEQ   = OP_W'(5);
    localparam logic [OP_W-1:0] OP_IN    = OP_W'(6);
    localparam logic [OP_W-1:0] OP_HALT  = OP_W'(7);

    state_t     state, nxt;
    logic [7:0] wait_cnt;
    logic       mem_st, timeout, taken;

    assign mem_st  = state inside {F1, E_RD, E_WR};
    // ready on the last permitted cycle still wins over the timeout
    assign timeout = !mem_ready && wait_cnt == 8'(WAIT_MAX - 1);
    assign taken   = (op == OP_BEQ) == z_flag;

    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= HOME;
            wait_cnt <= '0;
        end else begin
            state    <= nxt;
            wait_cnt <= (mem_st && nxt == state) ? wait_cnt + 8'd1 : '0;
        end
    end

    always_comb begin
        nxt       = state;
        PC_bus    = 1'b0;
        INC_PC    = 1'b0;
        load_PC   = 1'b0;
        load_MAR  = 1'b0;
        load_IR   = 1'b0;
        MDR_bus   = 1'b0;
        load_MDR  = 1'b0;
        ACC_bus   = 1'b0;
        load_ACC  = 1'b0;
        sw_bus    = 1'b0;
        Addr_bus  = 1'b0;
        ALU_sel   = 2'b00;
        mem_req   = 1'b0;
        CS        = 1'b0;
        R_NW      = 1'b1;
        halted    = 1'b0;
        bus_error = 1'b0;
        case (state)
            F0: begin
                PC_bus   = 1'b1;
                load_MAR = 1'b1;
                INC_PC   = 1'b1;
                load_PC  = 1'b1;
                nxt      = F1;
            end
            F1, E_RD: begin
                mem_req  = 1'b1;
                CS       = 1'b1;
                load_MDR = mem_ready;
                nxt      = mem_ready ? (state == F1 ? F2 : E_EX) : timeout ? ERR : state;
            end
            F2: begin
                MDR_bus = 1'b1;
                load_IR = 1'b1;
                nxt     = DEC;
            end
            DEC: case (op)
                OP_LOAD, OP_ADD, OP_SUB: begin
                    Addr_bus = 1'b1;
                    load_MAR = 1'b1;
                    nxt      = E_RD;
                end
                OP_STORE: begin
                    Addr_bus = 1'b1;
                    load_MAR = 1'b1;
                    ACC_bus  = 1'b1;
                    load_MDR = 1'b1;
                    nxt      = E_WR;
                end
                OP_BNE, OP_BEQ: begin
                    Addr_bus = taken;
                    load_PC  = taken;
                    nxt      = HOME;
                end
                OP_IN: begin
                    sw_bus   = 1'b1;
                    load_ACC = 1'b1;
                    nxt      = HOME;
                end
                OP_HALT: nxt = HALT;
            endcase
            E_EX: begin
                MDR_bus  = 1'b1;
                load_ACC = 1'b1;
                ALU_sel  = op == OP_ADD ? 2'b01 : op == OP_SUB ? 2'b10 : 2'b00;
                nxt      = HOME;
            end
            E_WR: begin
                mem_req = 1'b1;
                CS      = 1'b1;
                R_NW    = 1'b0;
                nxt     = mem_ready ? HOME : timeout ? ERR : E_WR;
            end
            HALT: halted = 1'b1;
            ERR: begin
                halted    = 1'b1;
                bus_error = 1'b1;
            end
`ifdef SEQ_SINGLE_STEP_EN
            STEP: nxt = step ? F0 : STEP;
`endif
            default: nxt = HOME;
        endcase
        // reset silences every strobe immediately, whatever state we are in
        if (reset) begin
            {PC_bus, INC_PC, load_PC, load_MAR, load_IR, MDR_bus, load_MDR, ACC_bus, load_ACC,
             sw_bus, Addr_bus, ALU_sel, mem_req, CS, R_NW, halted, bus_error} = '0;
            R_NW = 1'b1;
        end
    end
endmodule

// File: tb/tb_cpu_sequencer.sv
// tb_cpu_sequencer: builds per-cycle expected output schedules from instruction-level rules and checks the sequencer against them.
module tb_cpu_sequencer;
    localparam int WAIT_MAX = 15;

    localparam logic [17:0] PCB  = 18'd1 << 17;
    localparam logic [17:0] INC  = 18'd1 << 16;
    localparam logic [17:0] LPC  = 18'd1 << 15;
    localparam logic [17:0] MAR  = 18'd1 << 14;
    localparam logic [17:0] LIR  = 18'd1 << 13;
    localparam logic [17:0] MDRB = 18'd1 << 12;
    localparam logic [17:0] LMDR = 18'd1 << 11;
    localparam logic [17:0] ACCB = 18'd1 << 10;
    localparam logic [17:0] LACC = 18'd1 << 9;
    localparam logic [17:0] SW   = 18'd1 << 8;
    localparam logic [17:0] ADDR = 18'd1 << 7;
    localparam logic [17:0] REQ  = 18'd1 << 4;
    localparam logic [17:0] CSB  = 18'd1 << 3;
    localparam logic [17:0] RNW  = 18'd1 << 2;
    localparam logic [17:0] HLT  = 18'd1 << 1;
    localparam logic [17:0] BERR = 18'd1;
    localparam logic [17:0] RD   = REQ | CSB | RNW;

    logic        clock, reset, z_flag, mem_ready;
    logic [2:0]  op;
    logic        PC_bus, INC_PC, load_PC, load_MAR, load_IR, MDR_bus, load_MDR, ACC_bus, load_ACC;
    logic        sw_bus, Addr_bus, mem_req, CS, R_NW, halted, bus_error;
    logic [1:0]  ALU_sel;
    logic [17:0] outv;
`ifdef SEQ_SINGLE_STEP_EN
    logic        step;
`endif

    int          n_chk = 0;
    int          n_fail = 0;
    logic [17:0] exp_q[$];
    bit          rdy_q[$];
    bit          stp_q[$];
    bit          dead = 0;

    cpu_sequencer #(.OP_W(3), .WAIT_MAX(WAIT_MAX)) dut (
        .clock(clock), .reset(reset), .op(op), .z_flag(z_flag), .mem_ready(mem_ready),
`ifdef SEQ_SINGLE_STEP_EN
        .step(step),
`endif
        .PC_bus(PC_bus), .INC_PC(INC_PC), .load_PC(load_PC), .load_MAR(load_MAR), .load_IR(load_IR),
        .MDR_bus(MDR_bus), .load_MDR(load_MDR), .ACC_bus(ACC_bus), .load_ACC(load_ACC),
        .sw_bus(sw_bus), .Addr_bus(Addr_bus), .ALU_sel(ALU_sel), .mem_req(mem_req), .CS(CS),
        .R_NW(R_NW), .halted(halted), .bus_error(bus_error)
    );

    assign outv = {PC_bus, INC_PC, load_PC, load_MAR, load_IR, MDR_bus, load_MDR, ACC_bus, load_ACC,
                   sw_bus, Addr_bus, ALU_sel, mem_req, CS, R_NW, halted, bus_error};

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [17:0] e);
        n_chk++;
        assert (outv === e) else begin
            n_fail++;
            $error("FAIL %s: outputs %h expected %h", tag, outv, e);
        end
    endtask

    task automatic push(input logic [17:0] e, input bit r, input bit s);
        exp_q.push_back(e);
        rdy_q.push_back(r);
        stp_q.push_back(s);
    endtask

    // a memory access: w wait cycles then one ready cycle, or a timeout into the error state
    task automatic mem_phase(input logic [17:0] busy, input logic [17:0] done, input int w, output bit ok);
        ok = w < WAIT_MAX;
        for (int i = 0; i < (ok ? w : WAIT_MAX); i++) push(busy, 1'b0, 1'($urandom));
        if (ok) push(done, 1'b1, 1'($urandom));
        else begin
            for (int i = 0; i < 4; i++) push(HLT | BERR | RNW, 1'($urandom), 1'($urandom));
            dead = 1;
        end
    endtask

    task automatic plan(input int o, input bit zz, input int wf, input int we);
        bit ok;
        bit tk;
        logic [17:0] alu;
`ifdef SEQ_SINGLE_STEP_EN
        repeat ($urandom_range(0, 2)) push(RNW, 1'($urandom), 1'b0);
        push(RNW, 1'($urandom), 1'b1);
`endif
        push(PCB | INC | LPC | MAR | RNW, 1'($urandom), 1'($urandom));
        mem_phase(RD, RD | LMDR, wf, ok);
        if (!ok) return;
        push(MDRB | LIR | RNW, 1'($urandom), 1'($urandom));
        tk  = (o == 4) ? !zz : zz;
        alu = (o == 2) ? (18'd1 << 5) : (o == 3) ? (18'd2 << 5) : 18'd0;
        case (o)
            1: begin
                push(ADDR | MAR | ACCB | LMDR | RNW, 1'($urandom), 1'($urandom));
                mem_phase(REQ | CSB, REQ | CSB, we, ok);
            end
            4, 5: push((tk ? ADDR | LPC : 18'd0) | RNW, 1'($urandom), 1'($urandom));
            6: push(SW | LACC | RNW, 1'($urandom), 1'($urandom));
            7: begin
                push(RNW, 1'($urandom), 1'($urandom));
                repeat (100) push(HLT | RNW, 1'($urandom), 1'($urandom));
                dead = 1;
            end
            default: begin
                push(ADDR | MAR | RNW, 1'($urandom), 1'($urandom));
                mem_phase(RD, RD | LMDR, we, ok);
                if (ok) push(MDRB | LACC | RNW | alu, 1'($urandom), 1'($urandom));
            end
        endcase
    endtask

    // entered and left just after a rising edge; n < 0 runs the whole schedule
    task automatic run(input int n);
        int k = 0;
        while (exp_q.size() > 0 && n != 0) begin
            mem_ready = rdy_q.pop_front();
`ifdef SEQ_SINGLE_STEP_EN
            step = stp_q.pop_front();
`else
            void'(stp_q.pop_front());
`endif
            @(negedge clock);
            chk($sformatf("op%0d_cyc%0d", op, k), exp_q.pop_front());
            @(posedge clock);
            #1;
            n--;
            k++;
        end
    endtask

    task automatic do_reset;
        reset = 1'b1;
        mem_ready = 1'($urandom);
        @(negedge clock);
        chk("reset_now", RNW);
        @(posedge clock);
        #1;
        @(negedge clock);
        chk("reset_after_edge", RNW);
        @(posedge clock);
        #1;
        reset = 1'b0;
        dead = 0;
        exp_q.delete();
        rdy_q.delete();
        stp_q.delete();
    endtask

    task automatic instr(input int o, input bit zz, input int wf, input int we);
        op = 3'(o);
        z_flag = zz;
        plan(o, zz, wf, we);
        run(-1);
        if (dead) do_reset;
    endtask

    initial begin
        reset = 1'b1;
        op = 3'd0;
        z_flag = 1'b0;
        mem_ready = 1'b0;
`ifdef SEQ_SINGLE_STEP_EN
        step = 1'b0;
`endif
        @(posedge clock);
        #1;
        do_reset;
        instr(0, 0, 0, 0);
        instr(1, 0, 0, 3);
        instr(4, 0, 0, 0);
        instr(4, 1, 0, 0);
        instr(5, 1, 0, 0);
        instr(5, 0, 0, 0);
        instr(6, 0, 0, 0);
        instr(6, 1, 0, 0);
        instr(2, 1, 2, 1);
        instr(3, 0, 1, 2);
        instr(0, 0, WAIT_MAX - 1, WAIT_MAX - 1);
        instr(1, 0, 0, WAIT_MAX - 1);
        instr(0, 0, WAIT_MAX, 0);
        instr(2, 0, 0, WAIT_MAX);
        instr(1, 1, 0, WAIT_MAX);
        // reset while E_RD is waiting: stop after two wait cycles of the execute read
        op = 3'd0;
        z_flag = 1'b0;
        plan(0, 0, 0, 5);
        run(exp_q.size() - 5);
        do_reset;
        instr(3, 0, 0, 0);
        for (int i = 0; i < 40; i++)
            instr($urandom_range(0, 6), 1'($urandom), $urandom_range(0, 4), $urandom_range(0, 4));
        instr(7, 0, 0, 0);
        instr(6, 0, 0, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/cpu_sequencer.md
Name: cpu_sequencer

Overview:
- FSM control unit for the 8-bit accumulator CPU.
- Runs the fetch/decode/execute cycle and drives every register-load, bus-enable and ALU-select line in the datapath.
- Owns the memory handshake (mem_req/mem_ready) and enforces a wait-state timeout.
- Sits inside CPU between the instruction register opcode field and the datapath/RAM.

Parameters:
- OP_W, 3, opcode field width; the encoding below requires 3.
- WAIT_MAX, 15, maximum cycles spent waiting for mem_ready before a bus error; 1..255.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- op  in  OP_W  opcode from IR.
- z_flag  in  1  accumulator-zero flag.
- mem_ready  in  1  memory transfer complete.
- PC_bus, INC_PC, load_PC, load_MAR, load_IR  out  1 each  PC and address control.
- MDR_bus, load_MDR, ACC_bus, load_ACC, sw_bus, Addr_bus  out  1 each  bus drivers and loads.
- ALU_sel  out  2  ALU function: 00 pass, 01 add, 10 sub.
- mem_req, CS, R_NW  out  1 each  memory strobe, chip select, read(1)/write(0).
- halted  out  1  core stopped.
- bus_error  out  1  sticky timeout flag.

Behaviour:
- States: F0, F1, F2, DEC, E_RD, E_EX, E_WR, HALT, ERR.
- Outputs are Moore, decoded from state. Exceptions: load_MDR in read states and DEC-state branch/IN loads, as noted below.
- Reset:
  - state=F0, wait counter=0, all outputs 0, R_NW=1.
  - reset asserted in any state, including mid-wait, HALT or ERR, returns the FSM to F0 on the next edge.
- F0: PC_bus=1, load_MAR=1, INC_PC=1, load_PC=1. Always -> F1.
- F1 (read): mem_req=CS=R_NW=1.
  - load_MDR = mem_ready.
  - mem_ready -> F2; otherwise stay.
- F2: MDR_bus=1, load_IR=1. Always -> DEC.
- Opcode encoding: 000 LOAD, 001 STORE, 010 ADD, 011 SUB, 100 BNE, 101 BEQ, 110 IN, 111 HALT.
- DEC actions by opcode:
  - LOAD/ADD/SUB: Addr_bus=1, load_MAR=1; -> E_RD.
  - STORE: Addr_bus=1, load_MAR=1, ACC_bus=1, load_MDR=1; -> E_WR.
  - BNE: if z_flag=0, Addr_bus=1 and load_PC=1. -> F0.
  - BEQ: if z_flag=1, Addr_bus=1 and load_PC=1. -> F0.
  - A not-taken branch asserts nothing and goes -> F0.
  - IN: sw_bus=1, load_ACC=1, ALU_sel=00; -> F0.
  - HALT: -> HALT.
- E_RD: same as F1; mem_ready -> E_EX.
- E_EX: MDR_bus=1, load_ACC=1.
  - ALU_sel: 00 for LOAD, 01 for ADD, 10 for SUB.
  - Always -> F0.
- E_WR: mem_req=CS=1, R_NW=0; mem_ready -> F0.
- HALT: halted=1; stays until reset.
- Wait counter (F1, E_RD, E_WR):
  - Counts cycles with mem_ready=0; cleared on state change.
  - When the count reaches WAIT_MAX with mem_ready still 0 -> ERR.
  - mem_ready=1 on the WAIT_MAX-th cycle completes normally; ready takes priority.
- ERR: bus_error=1, halted=1, all strobes 0; stays until reset.
- Zero-wait latencies, F0 to next F0:
  - LOAD/ADD/SUB: 6 cycles.
  - STORE: 5 cycles.
  - Branch/IN: 4 cycles.
  - Each wait cycle adds 1.
- mem_ready outside memory states is ignored.

Optional Feature:
- Macro: SEQ_SINGLE_STEP_EN.
- Defined:
  - Adds input port step (1 bit).
  - Adds state STEP, which is entered instead of F0 after every completed instruction and after reset.
  - STEP asserts no outputs and -> F0 when step=1, so exactly one instruction runs per step pulse.
  - reset still forces STEP.
- Undefined:
  - No step port and no STEP state.
  - Instructions execute back to back.

Test Plan:
- Reset, then LOAD (op=000) with mem_ready tied 1 -> state sequence F0,F1,F2,DEC,E_RD,E_EX,F0; load_ACC=1 with ALU_sel=00 for exactly one cycle.
- STORE with mem_ready held 0 for 3 cycles in E_WR -> R_NW=0 and mem_req=1 for 4 cycles; return to F0 on cycle 8 after F0.
- BNE with z_flag=0 -> load_PC=1 and Addr_bus=1 in DEC. BNE with z_flag=1 -> neither asserted; both take 4 cycles.
- mem_ready stuck 0 in F1, WAIT_MAX=15 -> ERR after 15 wait cycles; bus_error=halted=1; reset returns to F0 with bus_error=0.
- op=111 -> halted=1 and held for 100 cycles. Reset asserted mid-E_RD wait -> F0 next edge, all outputs 0.
- With SEQ_SINGLE_STEP_EN, two IN instructions and one step pulse -> exactly one load_ACC pulse; a second pulse gives the second.
